// File: rtl/btn_conditioner_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btn_conditioner_n
// Brief    : N-channel button front end with the chain invert, 2-FF sync,
//            debounce, rise detect and tick-aligned press with hold-to-repeat.
//            Optional macro BTN_PRIORITY_EN: at most one press bit per tick,
//            lowest owed channel first.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner_n #(
  parameter int NUM_CH     = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int DB_CYCLES  = 250000,
  parameter int RPT_DELAY  = 20,
  parameter int RPT_PERIOD = 5
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic              tick,
  input  logic [NUM_CH-1:0] rpt_en,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press
);

  localparam int c_DB_W    = $clog2(DB_CYCLES + 1);
  localparam int c_RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int c_CNT_W   = $clog2(c_RPT_MAX + 1);

  localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(RPT_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DELAY  = 2'd2,
    S_REPEAT = 2'd3
  } state_t;

  logic [NUM_CH-1:0] w_in;
  logic [NUM_CH-1:0] w_fire;
  logic [NUM_CH-1:0] r_press;

  assign w_in  = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign press = r_press;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_DB_W-1:0]  r_db_cnt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_rise;
    logic               w_hold;
    logic               w_fire_ch;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_db_cnt  <= '0;
      end else begin
        r_sync1   <= w_in[i];
        r_sync2   <= r_sync1;
        r_level_d <= r_level;
        if (r_sync2 == r_level) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          r_level  <= ~r_level;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    assign w_rise = r_level & ~r_level_d;
    assign w_hold = r_level & rpt_en[i];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fire_ch   = 1'b0;
      case (r_state)
        S_IDLE, S_ARMED: begin
          // A rise coinciding with the tick is served by that same tick.
          if ((r_state == S_ARMED || w_rise) && tick) begin
            w_fire_ch   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = w_hold ? S_DELAY : S_IDLE;
          end else if (w_rise) begin
            w_state_nxt = S_ARMED;
          end
        end
        S_DELAY: begin
          if (!w_hold) begin
            w_state_nxt = S_IDLE;
          end else if (tick) begin
            if (r_cnt == c_DELAY_LAST) begin
              w_fire_ch   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_REPEAT;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (!w_hold) begin
            w_state_nxt = S_IDLE;
          end else if (tick) begin
            if (r_cnt == c_PERIOD_LAST) begin
              w_fire_ch = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    assign w_fire[i] = w_fire_ch;
    assign level[i]  = r_level;
  end

`ifdef BTN_PRIORITY_EN
  logic [NUM_CH-1:0] r_owed;
  logic [NUM_CH-1:0] w_due;
  logic [NUM_CH-1:0] w_grant;

  // Owed presses saturate at one per channel and are only granted on a tick.
  always_comb begin
    w_due   = r_owed | w_fire;
    w_grant = '0;
    if (tick) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (w_due[k]) begin
          w_grant    = '0;
          w_grant[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_owed  <= '0;
      r_press <= '0;
    end else begin
      r_owed  <= w_due & ~w_grant;
      r_press <= w_grant;
    end
  end
`else
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_press <= '0;
    end else begin
      r_press <= w_fire;
    end
  end
`endif

endmodule
`default_nettype wire
